// File: rtl/mem_arbiter_2to1.sv
// Two-master round-robin arbiter onto one sp_ram port. An owner FIFO routes each rvalid back to the master that issued the request.
// Optional grant counters are built only when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter_2to1 #(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    input  logic                    m1_req_i,
    output logic                    m0_gnt_o,
    output logic                    m1_gnt_o,
    output logic                    m0_rvalid_o,
    output logic                    m1_rvalid_o,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic                    m0_we_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m0_err_o,
    output logic                    m1_err_o,
    output logic                    s_req_o,
    input  logic                    s_gnt_i,
    input  logic                    s_rvalid_i,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_be_o,
    output logic [DATA_WIDTH-1:0]   s_wdata_o,
    input  logic [DATA_WIDTH-1:0]   s_rdata_i,
    output logic                    proto_err_o,
    output logic [31:0]             gnt_cnt0_o,
    output logic [31:0]             gnt_cnt1_o
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    typedef enum logic {ARB, HOLD} state_e;

    state_e                     state_q, state_d;
    logic                       hold_id_q, hold_id_d;
    logic                       last_grant_q, last_grant_d;
    logic                       sel;
    logic                       sel_req;
    logic                       full;
    logic                       push;
    logic                       pop;
    logic                       head;
    logic [MAX_OUTSTANDING-1:0] owner_q;
    logic [PW-1:0]              wptr_q, rptr_q;
    logic [CW-1:0]              count_q;
    logic                       proto_err_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ARB;
            hold_id_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            hold_id_q    <= hold_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hold_id_d = hold_id_q;
        case (state_q)
            ARB: begin
                if (s_req_o && !s_gnt_i) begin
                    state_d   = HOLD;
                    hold_id_d = sel;
                end
            end
            HOLD: begin
                if (s_gnt_i) state_d = ARB;
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        sel = 1'b0;
        case (state_q)
            ARB: begin
                if (m0_req_i && m1_req_i) sel = ~last_grant_q;
                else                      sel = m1_req_i;
            end
            HOLD:    sel = hold_id_q;
            default: sel = 1'b0;
        endcase
    end

    // Full check nets out a same-cycle pop so a full FIFO can still accept.
    assign pop     = s_rvalid_i && (count_q != '0);
    assign full    = (count_q - CW'(pop)) == CW'(MAX_OUTSTANDING);
    assign sel_req = sel ? m1_req_i : m0_req_i;
    assign s_req_o = !rst_i && sel_req && !full;
    assign push    = s_req_o && s_gnt_i;
    assign head    = owner_q[rptr_q];

    assign last_grant_d = push ? sel : last_grant_q;

    assign s_addr_o  = sel ? m1_addr_i  : m0_addr_i;
    assign s_we_o    = sel ? m1_we_i    : m0_we_i;
    assign s_be_o    = sel ? m1_be_i    : m0_be_i;
    assign s_wdata_o = sel ? m1_wdata_i : m0_wdata_i;

    assign m0_gnt_o    = push && !sel;
    assign m1_gnt_o    = push && sel;
    assign m0_rvalid_o = pop && !head;
    assign m1_rvalid_o = pop && head;
    assign m0_rdata_o  = s_rdata_i;
    assign m1_rdata_o  = s_rdata_i;
    assign m0_err_o    = 1'b0;
    assign m1_err_o    = 1'b0;
    assign proto_err_o = proto_err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            owner_q     <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (push) begin
                owner_q[wptr_q] <= sel;
                wptr_q          <= ptr_inc(wptr_q);
            end
            if (pop) rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + CW'(push) - CW'(pop);
            if (s_rvalid_i && (count_q == '0)) proto_err_q <= 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt1_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (m0_gnt_o) gnt_cnt0_q <= gnt_cnt0_q + 32'd1;
            if (m1_gnt_o) gnt_cnt1_q <= gnt_cnt1_q + 32'd1;
        end
    end

    assign gnt_cnt0_o = gnt_cnt0_q;
    assign gnt_cnt1_o = gnt_cnt1_q;
`else
    assign gnt_cnt0_o = '0;
    assign gnt_cnt1_o = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Directed bench for mem_arbiter_2to1; the bench plays the slave by driving s_gnt_i/s_rvalid_i itself.
module tb_mem_arbiter_2to1;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, m0_rdata, m1_rdata;
    logic        m0_we, m1_we, m0_err, m1_err;
    logic [3:0]  m0_be, m1_be, s_be;
    logic        s_req, s_gnt, s_rvalid, s_we, proto_err;
    logic [31:0] s_addr, s_wdata, s_rdata, cnt0, cnt1;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m1_req_i(m1_req), .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
        .m0_rvalid_o(m0_rvalid), .m1_rvalid_o(m1_rvalid),
        .m0_addr_i(m0_addr), .m1_addr_i(m1_addr), .m0_we_i(m0_we), .m1_we_i(m1_we),
        .m0_be_i(m0_be), .m1_be_i(m1_be), .m0_wdata_i(m0_wdata), .m1_wdata_i(m1_wdata),
        .m0_rdata_o(m0_rdata), .m1_rdata_o(m1_rdata), .m0_err_o(m0_err), .m1_err_o(m1_err),
        .s_req_o(s_req), .s_gnt_i(s_gnt), .s_rvalid_i(s_rvalid),
        .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_rdata_i(s_rdata), .proto_err_o(proto_err),
        .gnt_cnt0_o(cnt0), .gnt_cnt1_o(cnt1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 0; m1_req = 0; s_gnt = 0; s_rvalid = 0; s_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        m0_addr = 32'h100; m1_addr = 32'h300; m0_we = 0; m1_we = 1;
        m0_be = 4'hF; m1_be = 4'h3; m0_wdata = 32'h1111_0000; m1_wdata = 32'h2222_0000;
        tick();
        // Outputs must stay quiet while reset is held, whatever the inputs do.
        m0_req = 1; m1_req = 1; s_gnt = 1; s_rvalid = 1;
        settle();
        check("rst_s_req", {31'd0, s_req}, 32'd0);
        check("rst_m0_gnt", {31'd0, m0_gnt}, 32'd0);
        check("rst_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        check("rst_rvalid", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
        tick();
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_cnt0", cnt0, 32'd0);
        check("rst_cnt1", cnt1, 32'd0);
        idle_inputs();
        rst = 0;
        tick();

        // Single master read of 0x100
        m0_req = 1; s_gnt = 1;
        settle();
        check("single_s_req", {31'd0, s_req}, 32'd1);
        check("single_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        check("single_m1_gnt", {31'd0, m1_gnt}, 32'd0);
        check("single_addr", s_addr, 32'h100);
        check("single_we", {31'd0, s_we}, 32'd0);
        check("single_be", {28'd0, s_be}, 32'hF);
        tick();
        m0_req = 0; s_gnt = 0; s_rvalid = 1; s_rdata = 32'hDEAD_0100;
        settle();
        check("single_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        check("single_m0_rdata", m0_rdata, 32'hDEAD_0100);
        check("single_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
        check("single_err", {30'd0, m1_err, m0_err}, 32'd0);
        tick();
        s_rvalid = 0;

        // Contention: alternating grants starting with m0, responses in order
        do_reset();
        m0_addr = 32'h200; m1_addr = 32'h300;
        for (int i = 0; i < 8; i++) begin
            m0_req = 1; m1_req = 1; s_gnt = 1;
            s_rvalid = (i > 0); s_rdata = 32'hC000_0000 + i;
            settle();
            check($sformatf("cont_m0_gnt%0d", i), {31'd0, m0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("cont_m1_gnt%0d", i), {31'd0, m1_gnt}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check($sformatf("cont_addr%0d", i), s_addr, (i % 2 == 0) ? 32'h200 : 32'h300);
            if (i > 0) begin
                check($sformatf("cont_m0_rv%0d", i), {31'd0, m0_rvalid}, ((i - 1) % 2 == 0) ? 32'd1 : 32'd0);
                check($sformatf("cont_m1_rv%0d", i), {31'd0, m1_rvalid}, ((i - 1) % 2 == 1) ? 32'd1 : 32'd0);
            end
            tick();
        end
        idle_inputs();
        s_rvalid = 1; s_rdata = 32'hC000_00FF;
        settle();
        check("cont_last_m1_rv", {31'd0, m1_rvalid}, 32'd1);
        check("cont_last_m1_rdata", m1_rdata, 32'hC000_00FF);
        check("cont_last_m0_rv", {31'd0, m0_rvalid}, 32'd0);
        tick();
        s_rvalid = 0;

        // Stall: m1 selected and held while m0 joins
        m1_addr = 32'h400; m0_addr = 32'h500;
        m1_req = 1;
        settle();
        check("stall_s_req0", {31'd0, s_req}, 32'd1);
        check("stall_addr0", s_addr, 32'h400);
        tick();
        m0_req = 1;
        for (int i = 1; i < 3; i++) begin
            settle();
            check($sformatf("stall_addr%0d", i), s_addr, 32'h400);
            check($sformatf("stall_m0_gnt%0d", i), {31'd0, m0_gnt}, 32'd0);
            check($sformatf("stall_s_req%0d", i), {31'd0, s_req}, 32'd1);
            tick();
        end
        s_gnt = 1;
        settle();
        check("stall_m1_gnt", {31'd0, m1_gnt}, 32'd1);
        check("stall_m0_gnt_rel", {31'd0, m0_gnt}, 32'd0);
        tick();
        m1_req = 0; s_rvalid = 1; s_rdata = 32'h0000_0400;
        settle();
        check("stall_m0_next", {31'd0, m0_gnt}, 32'd1);
        check("stall_m0_addr", s_addr, 32'h500);
        check("stall_m1_rv", {31'd0, m1_rvalid}, 32'd1);
        tick();
        m0_req = 0; s_gnt = 0;
        settle();
        check("stall_m0_rv", {31'd0, m0_rvalid}, 32'd1);
        tick();
        s_rvalid = 0;

        // FIFO full: two outstanding, third waits for the first rvalid
        m0_req = 1; s_gnt = 1;
        settle();
        check("full_gnt_a", {31'd0, m0_gnt}, 32'd1);
        tick();
        settle();
        check("full_gnt_b", {31'd0, m0_gnt}, 32'd1);
        tick();
        settle();
        check("full_s_req_blocked", {31'd0, s_req}, 32'd0);
        check("full_gnt_blocked", {31'd0, m0_gnt}, 32'd0);
        tick();
        s_rvalid = 1;
        settle();
        check("full_s_req_pop", {31'd0, s_req}, 32'd1);
        check("full_gnt_pop", {31'd0, m0_gnt}, 32'd1);
        check("full_rv_a", {31'd0, m0_rvalid}, 32'd1);
        tick();
        m0_req = 0; s_gnt = 0;
        settle();
        check("full_rv_b", {31'd0, m0_rvalid}, 32'd1);
        tick();
        settle();
        check("full_rv_c", {31'd0, m0_rvalid}, 32'd1);
        tick();

        // Protocol error: rvalid with nothing outstanding
        settle();
        check("perr_no_m0_rv", {31'd0, m0_rvalid}, 32'd0);
        check("perr_no_m1_rv", {31'd0, m1_rvalid}, 32'd0);
        check("perr_before", {31'd0, proto_err}, 32'd0);
        tick();
        s_rvalid = 0;
        settle();
        check("perr_set", {31'd0, proto_err}, 32'd1);
        tick();
        tick();
        check("perr_sticky", {31'd0, proto_err}, 32'd1);

        // Counters: 5 m0 grants, 3 m1 grants, last m0 transaction left outstanding
        do_reset();
        check("cnt_reset_perr", {31'd0, proto_err}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            m0_req = 1; m1_req = (i < 6); s_gnt = 1; s_rvalid = (i > 0);
            settle();
            check($sformatf("cnt_m0_gnt%0d", i), {31'd0, m0_gnt},
                  (i >= 6 || i % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        idle_inputs();
`ifdef MEM_ARB_PERF_CNT_EN
        check("gnt_cnt0", cnt0, 32'd5);
        check("gnt_cnt1", cnt1, 32'd3);
`else
        check("gnt_cnt0", cnt0, 32'd0);
        check("gnt_cnt1", cnt1, 32'd0);
`endif

        // Reset with an m0 read in flight: the late rvalid is orphaned
        do_reset();
        check("midrst_cnt0", cnt0, 32'd0);
        s_rvalid = 1;
        settle();
        check("midrst_no_m0_rv", {31'd0, m0_rvalid}, 32'd0);
        check("midrst_no_m1_rv", {31'd0, m1_rvalid}, 32'd0);
        tick();
        s_rvalid = 0;
        check("midrst_perr", {31'd0, proto_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
